pipeline_ctrl: RTL and testbench

// - Sequences the RV32I 5-stage pipeline: per-stage register enables and flushes.
// - Handles three events: load-use stalls, branch/jump redirect squashes, and multi-cycle data-memory waits.
// - Drives the dmem req/ack handshake and a timeout.
// - Sits beside the forwarding/hazard logic; its outputs gate the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline controller.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_e;

  // True when the ID instruction needs the value a load in EX has not produced yet.
  function automatic logic load_use_hit(
    input logic [REG_ADDR_W-1:0] id_rs1,
    input logic [REG_ADDR_W-1:0] id_rs2,
    input logic                  id_uses_rs2,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_mem_read
  );
    return ex_mem_read && (ex_rd != X0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, stage controls and dmem handshake between the controller and the datapath.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  is_branch;
  logic                  jump;
  logic                  mem_access;
  logic                  dmem_ack;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  mem_wb_flush;
  logic                  dmem_req;
  logic                  dmem_timeout;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, is_branch, jump, mem_access,
           dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           mem_wb_flush, dmem_req, dmem_timeout, stall_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, is_branch, jump, mem_access,
           dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           mem_wb_flush, dmem_req, dmem_timeout, stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// RV32I 5-stage pipeline sequencer: stage enables/flushes for load-use, redirect and dmem waits.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic load_use, redirect, freeze, timeout;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic dmem_req, dmem_timeout;

  always_comb begin
    load_use = load_use_hit(bus.id_rs1, bus.id_rs2, bus.id_uses_rs2, bus.ex_rd,
                            bus.ex_mem_read);
    redirect = bus.is_branch | bus.jump;
    freeze   = bus.mem_access & ~bus.dmem_ack;
    timeout  = (state_q == MEM_WAIT) && freeze && (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = bus.mem_access;
    dmem_timeout = 1'b0;
    state_d      = RUN;
    wait_cnt_d   = '0;

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      dmem_req     = 1'b0;
    end else if (freeze && !timeout) begin
      // Hold everything up to EX/MEM; MEM/WB takes a bubble while dmem is busy.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = MEM_WAIT;
      wait_cnt_d   = (state_q == RUN) ? WAIT_W'(1) : wait_cnt_q + WAIT_W'(1);
    end else begin
      if (redirect) begin
        // The squash also kills any load-use victim sitting in ID.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      if (timeout) begin
        dmem_timeout = 1'b1;
        dmem_req     = 1'b0;
        mem_wb_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clear (~rst_n),
    .inc   (~pc_en),
    .count (bus.stall_cnt)
  );

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.dmem_req     = dmem_req;
  assign bus.dmem_timeout = dmem_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner sequences, random vs model.
module tb_pipeline_ctrl;

  localparam int unsigned TIMEOUT = 16;

  // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb en | if_id, id_ex, mem_wb flush | req | to
  localparam logic [9:0] O_RUN    = 10'b1111100000;
  localparam logic [9:0] O_FROZEN = 10'b0000100110;
  localparam logic [9:0] O_RESET  = 10'b0000011100;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       jmp;
    logic       mem;
    logic       ack;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32)) bus32 ();
  pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

  pipeline_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (32)
  ) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  pipeline_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (4)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  function automatic in_t mk(int rs1, int rs2, int uses, int rd, int mr, int br, int jmp,
                             int mem, int ack);
    in_t v;
    v.rst_n = 1'b1;
    v.rs1 = 5'(rs1);
    v.rs2 = 5'(rs2);
    v.uses = 1'(uses);
    v.rd = 5'(rd);
    v.mr = 1'(mr);
    v.br = 1'(br);
    v.jmp = 1'(jmp);
    v.mem = 1'(mem);
    v.ack = 1'(ack);
    return v;
  endfunction

  function automatic logic [9:0] outs32();
    return {bus32.pc_en, bus32.if_id_en, bus32.id_ex_en, bus32.ex_mem_en, bus32.mem_wb_en,
            bus32.if_id_flush, bus32.id_ex_flush, bus32.mem_wb_flush, bus32.dmem_req,
            bus32.dmem_timeout};
  endfunction

  // Reference: streak = consecutive prior cycles the MEM access sat unacknowledged.
  function automatic logic [9:0] model_outs(in_t v, int streak);
    logic       lu, stalled, to;
    logic [9:0] o;
    if (!v.rst_n) return O_RESET;
    lu      = v.mr && (v.rd != 0) && ((v.rd == v.rs1) || (v.uses && (v.rd == v.rs2)));
    stalled = v.mem && !v.ack;
    to      = stalled && (streak == int'(TIMEOUT) - 1);
    if (stalled && !to) return O_FROZEN;
    o = O_RUN;
    if (v.br || v.jmp) begin
      o[4] = 1'b1;
      o[3] = 1'b1;
    end else if (lu) begin
      o[9] = 1'b0;
      o[8] = 1'b0;
      o[3] = 1'b1;
    end
    if (to) begin
      o[2] = 1'b1;
      o[1] = 1'b0;
      o[0] = 1'b1;
    end else begin
      o[1] = v.mem;
    end
    return o;
  endfunction

  task automatic drive(in_t v);
    rst_n = v.rst_n;
    bus32.id_rs1 = v.rs1;      bus4.id_rs1 = v.rs1;
    bus32.id_rs2 = v.rs2;      bus4.id_rs2 = v.rs2;
    bus32.id_uses_rs2 = v.uses; bus4.id_uses_rs2 = v.uses;
    bus32.ex_rd = v.rd;        bus4.ex_rd = v.rd;
    bus32.ex_mem_read = v.mr;  bus4.ex_mem_read = v.mr;
    bus32.is_branch = v.br;    bus4.is_branch = v.br;
    bus32.jump = v.jmp;        bus4.jump = v.jmp;
    bus32.mem_access = v.mem;  bus4.mem_access = v.mem;
    bus32.dmem_ack = v.ack;    bus4.dmem_ack = v.ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Apply v, compare outputs mid-cycle, then let the clock edge take it.
  task automatic step(string name, in_t v, logic [9:0] exp);
    drive(v);
    @(negedge clk);
    chk(name, 32'(outs32()), 32'(exp));
    tick();
  endtask

  task automatic do_reset();
    in_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst_n = 1'b0;
    drive(v);
    tick();
    tick();
  endtask

  task automatic frozen_run(string name, int n);
    for (int i = 0; i < n; i++) step(name, mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_FROZEN);
  endtask

  vec_t vecs[10];

  initial begin
    in_t    v;
    int     streak;
    longint cnt32, cnt4;
    int     mem_p, ack_p, seg;
    logic [9:0] e;

    vecs[0] = '{"no_hazard",     mk(1, 2, 1, 3, 1, 0, 0, 0, 0), O_RUN};
    vecs[1] = '{"lu_rs1",        mk(5, 2, 0, 5, 1, 0, 0, 0, 0), 10'b0011101000};
    vecs[2] = '{"lu_rs2",        mk(1, 5, 1, 5, 1, 0, 0, 0, 0), 10'b0011101000};
    vecs[3] = '{"rs2_unused",    mk(1, 5, 0, 5, 1, 0, 0, 0, 0), O_RUN};
    vecs[4] = '{"load_x0",       mk(0, 0, 1, 0, 1, 0, 0, 0, 0), O_RUN};
    vecs[5] = '{"no_load_match", mk(5, 5, 1, 5, 0, 0, 0, 0, 0), O_RUN};
    vecs[6] = '{"branch_over_lu", mk(5, 2, 0, 5, 1, 1, 0, 0, 0), 10'b1111111000};
    vecs[7] = '{"jump",          mk(1, 2, 1, 3, 0, 0, 1, 0, 0), 10'b1111111000};
    vecs[8] = '{"mem_ack_now",   mk(1, 2, 1, 3, 0, 0, 0, 1, 1), 10'b1111100010};
    vecs[9] = '{"mem_ack_lu",    mk(4, 2, 0, 4, 1, 0, 0, 1, 1), 10'b0011101010};

    // Reset state
    v = mk(0, 0, 0, 0, 0, 1, 0, 1, 0);
    v.rst_n = 1'b0;
    drive(v);
    tick();
    @(negedge clk);
    chk("reset_outs", 32'(outs32()), 32'(O_RESET));
    chk("reset_stall_cnt", bus32.stall_cnt, 32'd0);
    tick();

    // Single-cycle decode table, all from RUN
    do_reset();
    for (int i = 0; i < 10; i++) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // lw x5; add x6,x5,x1 back-to-back: one bubble
    do_reset();
    step("lu_seq_bubble", mk(5, 1, 1, 5, 1, 0, 0, 0, 0), 10'b0011101000);
    step("lu_seq_release", mk(7, 8, 1, 6, 0, 0, 0, 0, 0), O_RUN);
    @(negedge clk);
    chk("lu_seq_stall_cnt", bus32.stall_cnt, 32'd1);

    // Ack on the 4th cycle
    do_reset();
    frozen_run("ack4_frozen", 3);
    step("ack4_release", mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 10'b1111100010);
    @(negedge clk);
    chk("ack4_stall_cnt", bus32.stall_cnt, 32'd3);

    // Never acked: abort on wait cycle 15, then back to RUN
    do_reset();
    frozen_run("to_frozen", 15);
    step("to_pulse", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 10'b1111100101);
    @(negedge clk);
    chk("to_stall_cnt", bus32.stall_cnt, 32'd15);
    step("to_after", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_FROZEN);

    // Ack landing on the timeout cycle wins
    do_reset();
    frozen_run("to_ack_frozen", 15);
    step("to_ack_release", mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 10'b1111100010);

    // Branch held in EX across a wait, acted on at release
    do_reset();
    for (int i = 0; i < 2; i++) step("br_wait_frozen", mk(0, 0, 0, 0, 0, 1, 0, 1, 0), O_FROZEN);
    step("br_wait_release", mk(0, 0, 0, 0, 0, 1, 0, 1, 1), 10'b1111111010);

    // mem_access drops without ack: no pulse, no flush
    do_reset();
    frozen_run("drop_frozen", 4);
    step("drop_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_RUN);

    // Reset mid wait clears state, wait count and stall count
    do_reset();
    frozen_run("midrst_frozen", 3);
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    v.rst_n = 1'b0;
    step("midrst_in_reset", v, O_RESET);
    @(negedge clk);
    chk("midrst_stall_cnt", bus32.stall_cnt, 32'd0);
    step("midrst_no_req", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_RUN);
    frozen_run("midrst_wait_fresh", 15);
    step("midrst_to_pulse", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 10'b1111100101);

    // Saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(mk(5, 0, 0, 5, 1, 0, 0, 0, 0));
      tick();
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("sat_cnt4", 32'(bus4.stall_cnt), 32'd15);
    chk("sat_cnt32", bus32.stall_cnt, 32'd20);

    // Randomized traffic against the reference model
    do_reset();
    streak = 0;
    cnt32  = 0;
    cnt4   = 0;
    seg    = 0;
    mem_p  = 0;
    ack_p  = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        seg   = int'($urandom_range(5, 40));
        mem_p = int'($urandom_range(0, 2)) * 50;
        ack_p = (int'($urandom_range(0, 2)) == 0) ? 0 : int'($urandom_range(5, 60));
      end
      seg--;
      v.rst_n = ($urandom % 200) != 0;
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.uses  = 1'($urandom % 2);
      v.rd    = 5'($urandom_range(0, 3));
      v.mr    = ($urandom % 3) != 0;
      v.br    = ($urandom % 8) == 0;
      v.jmp   = ($urandom % 10) == 0;
      v.mem   = int'($urandom_range(0, 99)) < mem_p;
      v.ack   = int'($urandom_range(0, 99)) < ack_p;
      drive(v);
      @(negedge clk);
      e = model_outs(v, streak);
      chk("rand_outs", 32'(outs32()), 32'(e));
      chk("rand_cnt32", bus32.stall_cnt, 32'(cnt32));
      chk("rand_cnt4", 32'(bus4.stall_cnt), 32'(cnt4));
      if (!v.rst_n) begin
        streak = 0;
        cnt32  = 0;
        cnt4   = 0;
      end else begin
        if (!e[9]) begin
          if (cnt32 < 64'hFFFF_FFFF) cnt32++;
          if (cnt4 < 15) cnt4++;
        end
        if (v.mem && !v.ack && (streak != int'(TIMEOUT) - 1)) streak++;
        else streak = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
